// File: rtl/regfile_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file writeback arbiter.
//   DATA_W   : register data width
//   ADDR_W   : register address width
//   NUM_REGS : number of architectural registers (2**ADDR_W)
//   PC_REG   : register index that holds the externally supplied PC
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int PC_REG   = 15;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter_if
// Writeback request bus between the requesters and the arbiter.
//   req_valid : per-requester write request
//   req_addr  : destination register, requester i at slice i
//   req_data  : write data, requester i at slice i
//   req_ready : one-hot grant back to the requesters
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Generic N-way round-robin arbiter. The grant is combinational from req and
// the priority pointer; the pointer moves past the winner only when advance
// is high.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   advance    : accept the current grant and rotate priority
//   gnt        : one-hot (or zero) grant
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    // Index of the highest-priority requester (last grant + 1).
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     masked;

    always_comb begin
        gnt    = '0;
        ptr_d  = ptr_q;
        masked = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (i >= int'(ptr_q));
        end
        // Lowest set bit at or above the pointer wins; if none, wrap around
        // to the lowest set bit overall. Scanning downward leaves the lowest.
        if (|masked) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (masked[i]) begin
                    gnt    = '0;
                    gnt[i] = 1'b1;
                    ptr_d  = PTR_W'((i + 1) % N);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt    = '0;
                    gnt[i] = 1'b1;
                    ptr_d  = PTR_W'((i + 1) % N);
                end
            end
        end
        if (!advance) begin
            ptr_d = ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single register-file write port between N_REQ writeback
// requesters with round-robin fairness, registers the winning write, keeps a
// per-register busy scoreboard and drops writes to the PC register.
//   clk, rst_n     : clock, asynchronous active-low reset
//   wb             : requester bus (req_valid/addr/data in, req_ready out)
//   rsv_valid/addr : issue-stage reservation of a destination register
//   rf_wr/wa/wd    : registered register-file write port
//   busy           : scoreboard, bit r set while a write to r is pending
//   err_pc_write   : pulse, a granted request targeted the PC register
//   err_sb         : pulse, reserve of a busy reg or write to a non-busy reg
// Optional feature macro REGFILE_WB_BYPASS_EN adds two same-cycle bypass read
// ports (byp_ra1/2 in, byp_hit1/2 and byp_d1/2 out).
// ----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int PC_REG = regfile_pkg::PC_REG
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_write_arbiter_if.slave wb,
    input  logic                   rsv_valid,
    input  logic [ADDR_W-1:0]      rsv_addr,
    output logic                   rf_wr,
    output logic [ADDR_W-1:0]      rf_wa,
    output logic [DATA_W-1:0]      rf_wd,
    output logic [2**ADDR_W-1:0]   busy,
    output logic                   err_pc_write,
    output logic                   err_sb
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]      byp_ra1,
    input  logic [ADDR_W-1:0]      byp_ra2,
    output logic                   byp_hit1,
    output logic                   byp_hit2,
    output logic [DATA_W-1:0]      byp_d1,
    output logic [DATA_W-1:0]      byp_d2
`endif
);
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_REG);

    logic [N_REQ-1:0]      gnt;
    logic                  sel_vld;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic                  wr_ok, pc_hit, rsv_ok;

    logic                  wr_q, wr_d;
    logic [ADDR_W-1:0]     wa_q, wa_d;
    logic [DATA_W-1:0]     wd_q, wd_d;
    logic [2**ADDR_W-1:0]  busy_q, busy_d;
    logic                  pc_err_q, pc_err_d;
    logic                  sb_err_q, sb_err_d;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (wb.req_valid),
        .advance (sel_vld),
        .gnt     (gnt)
    );

    // Every grant is a transfer: ready is the grant itself.
    assign wb.req_ready = gnt;

    always_comb begin
        sel_vld  = |gnt;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = wb.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = wb.req_data[i*DATA_W +: DATA_W];
            end
        end

        wr_ok  = sel_vld && (sel_addr != PC_A);
        pc_hit = sel_vld && (sel_addr == PC_A);
        rsv_ok = rsv_valid && (rsv_addr != PC_A);

        wr_d     = wr_ok;
        pc_err_d = pc_hit;
        wa_d     = wr_ok ? sel_addr : wa_q;
        wd_d     = wr_ok ? sel_data : wd_q;

        // Clear first, then reserve, so a same-cycle reserve of the register
        // being written leaves it busy for the newly issued producer.
        busy_d = busy_q;
        if (wr_ok)  busy_d[sel_addr] = 1'b0;
        if (rsv_ok) busy_d[rsv_addr] = 1'b1;

        sb_err_d = (rsv_ok && busy_q[rsv_addr]) || (wr_ok && !busy_q[sel_addr]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            busy_q   <= '0;
            pc_err_q <= 1'b0;
            sb_err_q <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            busy_q   <= busy_d;
            pc_err_q <= pc_err_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign rf_wr        = wr_q;
    assign rf_wa        = wa_q;
    assign rf_wd        = wd_q;
    assign busy         = busy_q;
    assign err_pc_write = pc_err_q;
    assign err_sb       = sb_err_q;

`ifdef REGFILE_WB_BYPASS_EN
    // Decode reads the value being written this cycle before the RF has it.
    assign byp_hit1 = wr_q && (byp_ra1 == wa_q);
    assign byp_hit2 = wr_q && (byp_ra2 == wa_q);
    assign byp_d1   = byp_hit1 ? wd_q : '0;
    assign byp_d2   = byp_hit2 ? wd_q : '0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic clk;
    logic rst_n;
    logic rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;
    logic rf_wr;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [NUM_REGS-1:0] busy;
    logic err_pc_write;
    logic err_sb;
`ifdef REGFILE_WB_BYPASS_EN
    logic [ADDR_W-1:0] byp_ra1, byp_ra2;
    logic byp_hit1, byp_hit2;
    logic [DATA_W-1:0] byp_d1, byp_d2;
`endif

    regfile_write_arbiter_if #(.N_REQ(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) wbif ();

    regfile_write_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb           (wbif.slave),
        .rsv_valid    (rsv_valid),
        .rsv_addr     (rsv_addr),
        .rf_wr        (rf_wr),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .busy         (busy),
        .err_pc_write (err_pc_write),
        .err_sb       (err_sb)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .byp_ra1      (byp_ra1),
        .byp_ra2      (byp_ra2),
        .byp_hit1     (byp_hit1),
        .byp_hit2     (byp_hit2),
        .byp_d1       (byp_d1),
        .byp_d2       (byp_d2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: architectural view of the arbiter.
    logic [NUM_REGS-1:0] m_busy;
    int                  m_last;   // last granted requester
    int                  m_wa;
    logic [DATA_W-1:0]   m_wd;
    logic                m_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy = '0;
        m_last = 1;   // so the first search begins at requester 0
        m_wa   = 0;
        m_wd   = '0;
        m_wr   = 1'b0;
    endtask

    // One clock cycle: drive, check grant, clock, check registered results.
    task automatic cycle(input logic [1:0] v, input int a0, input int a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic rv, input int ra);
        int g;
        int ga;
        logic [31:0] gd;
        logic e_pc, e_sb;
        logic [NUM_REGS-1:0] nb;
        logic [1:0] e_ready;
        wbif.req_valid = v;
        wbif.req_addr  = {4'(a1), 4'(a0)};
        wbif.req_data  = {d1, d0};
        rsv_valid      = rv;
        rsv_addr       = 4'(ra);

        g = -1;
        for (int k = 1; k <= 2; k++) begin
            if (g < 0 && v[(m_last + k) % 2]) g = (m_last + k) % 2;
        end
        e_ready = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);

        e_pc = 1'b0;
        e_sb = 1'b0;
        m_wr = 1'b0;
        nb   = m_busy;
        if (g >= 0) begin
            m_last = g;
            ga = (g == 0) ? a0 : a1;
            gd = (g == 0) ? d0 : d1;
            if (ga == PC_REG) begin
                e_pc = 1'b1;
            end else begin
                m_wr = 1'b1;
                if (!m_busy[ga]) e_sb = 1'b1;
                m_wa = ga;
                m_wd = gd;
                nb[ga] = 1'b0;
            end
        end
        if (rv && ra != PC_REG) begin
            if (m_busy[ra]) e_sb = 1'b1;
            nb[ra] = 1'b1;
        end
        m_busy = nb;

`ifdef REGFILE_WB_BYPASS_EN
        byp_ra1 = $urandom_range(0, 1) ? 4'(m_wa) : 4'($urandom_range(0, 15));
        byp_ra2 = 4'($urandom_range(0, 15));
`endif
        #1;
        check("req_ready", 32'(wbif.req_ready), 32'(e_ready));
        @(posedge clk);
        #1;
        check("rf_wr", 32'(rf_wr), 32'(m_wr));
        check("rf_wa", 32'(rf_wa), 32'(m_wa));
        check("rf_wd", rf_wd, m_wd);
        check("busy", 32'(busy), 32'(m_busy));
        check("err_pc_write", 32'(err_pc_write), 32'(e_pc));
        check("err_sb", 32'(err_sb), 32'(e_sb));
`ifdef REGFILE_WB_BYPASS_EN
        check("byp_hit1", 32'(byp_hit1), 32'(m_wr && (int'(byp_ra1) == m_wa)));
        check("byp_d1", byp_d1, (m_wr && (int'(byp_ra1) == m_wa)) ? m_wd : 32'h0);
        check("byp_hit2", 32'(byp_hit2), 32'(m_wr && (int'(byp_ra2) == m_wa)));
        check("byp_d2", byp_d2, (m_wr && (int'(byp_ra2) == m_wa)) ? m_wd : 32'h0);
`endif
    endtask

    task automatic idle();
        cycle(2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
    endtask

    initial begin
        // Reset state
        rst_n          = 1'b0;
        wbif.req_valid = '0;
        wbif.req_addr  = '0;
        wbif.req_data  = '0;
        rsv_valid      = 1'b0;
        rsv_addr       = '0;
`ifdef REGFILE_WB_BYPASS_EN
        byp_ra1 = '0;
        byp_ra2 = '0;
`endif
        model_reset();
        #1;
        check("rst_rf_wr", 32'(rf_wr), 32'h0);
        check("rst_rf_wa", 32'(rf_wa), 32'h0);
        check("rst_rf_wd", rf_wd, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err_pc", 32'(err_pc_write), 32'h0);
        check("rst_err_sb", 32'(err_sb), 32'h0);
        check("rst_ready", 32'(wbif.req_ready), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single write: reserve r4, then ALU writes r4
        cycle(2'b00, 0, 0, 32'h0, 32'h0, 1'b1, 4);
        check("rsv_busy4", 32'(busy[4]), 32'h1);
        cycle(2'b01, 4, 0, 32'h4, 32'h0, 1'b0, 0);
        check("single_wr", 32'(rf_wr), 32'h1);
        check("single_wa", 32'(rf_wa), 32'h4);
        check("single_wd", rf_wd, 32'h4);
        check("single_busy4", 32'(busy[4]), 32'h0);
        idle();
        check("idle_wd_hold", rf_wd, 32'h4);

        // PC guard: MEM writes r15
        cycle(2'b10, 0, 15, 32'h0, 32'h4C, 1'b0, 0);
        check("pc_wr", 32'(rf_wr), 32'h0);
        check("pc_err", 32'(err_pc_write), 32'h1);

        // Contention: r3 and r5 reserved, both requesters valid for 4 cycles
        cycle(2'b00, 0, 0, 32'h0, 32'h0, 1'b1, 3);
        cycle(2'b00, 0, 0, 32'h0, 32'h0, 1'b1, 5);
        for (int i = 0; i < 4; i++) begin
            cycle(2'b11, 3, 5, 32'hF, 32'hA0, 1'b0, 0);
            check("cont_wa", 32'(rf_wa), (i % 2 == 0) ? 32'd3 : 32'd5);
        end

        // Scoreboard corner: reserve r7 while its pending write lands
        cycle(2'b00, 0, 0, 32'h0, 32'h0, 1'b1, 7);
        cycle(2'b01, 7, 0, 32'h77, 32'h0, 1'b1, 7);
        check("corner_busy7", 32'(busy[7]), 32'h1);
        cycle(2'b01, 2, 0, 32'h22, 32'h0, 1'b0, 0);
        check("corner_err_sb", 32'(err_sb), 32'h1);
        check("corner_wr", 32'(rf_wr), 32'h1);

        // Reserve of PC is ignored
        cycle(2'b00, 0, 0, 32'h0, 32'h0, 1'b1, 15);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            cycle(2'($urandom_range(0, 3)),
                  $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom, $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 15));
        end

        // Mid-stream reset with both requesters valid
        cycle(2'b00, 0, 0, 32'h0, 32'h0, 1'b1, 9);
        wbif.req_valid = 2'b11;
        wbif.req_addr  = {4'd6, 4'd9};
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr", 32'(rf_wr), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("mid_rst_hold_wr", 32'(rf_wr), 32'h0);
        rst_n = 1'b1;
        cycle(2'b11, 9, 6, 32'h99, 32'h66, 1'b0, 0);
        check("post_rst_wa", 32'(rf_wa), 32'h9);
        for (int i = 0; i < 50; i++) begin
            cycle(2'($urandom_range(0, 3)),
                  $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom, $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 15));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
